// File: rtl/prog_loader.sv
// Byte-serialising program loader: each accepted 32-bit word becomes four byte writes, LSB first, at t+1..t+4.
// word_ready is high only in WAIT, so a stalled source simply holds the loader there; the CPU stays held until a clean finish.
module prog_loader #(
   parameter int                    ADDR_WIDTH = 8,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
   parameter int                    MAX_WORDS  = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  word_valid,
   input  logic [31:0]           word_data,
   input  logic                  word_last,
   output logic                  word_ready,
   output logic [ADDR_WIDTH-1:0] mem_adr,
   output logic [7:0]            mem_wd,
   output logic                  mem_we,
   output logic                  cpu_hold,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   localparam int CW = $clog2(MAX_WORDS + 1);

   typedef enum logic [2:0] {
      ST_IDLE, ST_WAIT, ST_WR0, ST_WR1, ST_WR2, ST_WR3, ST_DONE, ST_ERR
   } state_t;

   state_t                  state, state_nxt;
   logic [ADDR_WIDTH-1:0]   addr;
   logic [CW-1:0]           count;
   logic [31:0]             word_q;
   logic                    last_q;
   logic                    restart;

   assign restart = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);
   assign mem_adr = addr;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= ST_IDLE;
         addr   <= BASE_ADDR;
         count  <= '0;
         word_q <= '0;
         last_q <= 1'b0;
      end else begin
         state <= state_nxt;
         if (restart) begin
            addr  <= BASE_ADDR;
            count <= '0;
         end
         if (state == ST_WAIT && word_valid) begin
            word_q <= word_data;
            last_q <= word_last;
            count  <= count + 1'b1;
         end
         if (mem_we) begin
            addr <= addr + 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt  = state;
      word_ready = 1'b0;
      mem_we     = 1'b0;
      mem_wd     = 8'h00;
      busy       = 1'b0;
      cpu_hold   = 1'b1;
      done       = 1'b0;
      error      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            word_ready = 1'b1;
            busy       = 1'b1;
            if (word_valid) state_nxt = ST_WR0;
         end
         ST_WR0: begin
            mem_we    = 1'b1;
            busy      = 1'b1;
            mem_wd    = word_q[7:0];
            state_nxt = ST_WR1;
         end
         ST_WR1: begin
            mem_we    = 1'b1;
            busy      = 1'b1;
            mem_wd    = word_q[15:8];
            state_nxt = ST_WR2;
         end
         ST_WR2: begin
            mem_we    = 1'b1;
            busy      = 1'b1;
            mem_wd    = word_q[23:16];
            state_nxt = ST_WR3;
         end
         ST_WR3: begin
            mem_we = 1'b1;
            busy   = 1'b1;
            mem_wd = word_q[31:24];
            // last takes priority so a full-length program that ends exactly at the limit still runs
            if (last_q)                        state_nxt = ST_DONE;
            else if (count == CW'(MAX_WORDS))  state_nxt = ST_ERR;
            else                               state_nxt = ST_WAIT;
         end
         ST_DONE: begin
            cpu_hold = 1'b0;
            done     = 1'b1;
            if (start) state_nxt = ST_WAIT;
         end
         ST_ERR: begin
            error = 1'b1;
            if (start) state_nxt = ST_WAIT;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule
